// File: rtl/mips_data_mem_sized_pkg.sv
// Shared definitions for the sized MIPS data memory: access-size encodings,
// FSM state encodings and the word width in bytes.
package mips_data_mem_sized_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mips_mem_lane_align.sv
// Combinational byte-lane steering for the data memory (little-endian lanes).
//   size        : access size encoding
//   addr_lo     : byte offset within the word (lane select)
//   zero_ext    : 1 = zero-extend byte/half loads
//   old_word    : current contents of the addressed word
//   store_data  : right-justified store data
//   store_word  : old_word with the addressed lane(s) replaced
//   load_word   : extracted and extended load result
module mips_mem_lane_align
    import mips_data_mem_sized_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        zero_ext,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] store_word,
    output logic [31:0] load_word
);

    logic [3:0]  lane_en;
    logic [31:0] wide;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Replicate the store data across lanes so each lane just picks its slice.
    always_comb begin
        lane_en = 4'b0000;
        wide    = store_data;
        case (size)
            MEM_SIZE_BYTE: begin
                lane_en = 4'b0001 << addr_lo;
                wide    = {4{store_data[7:0]}};
            end
            MEM_SIZE_HALF: begin
                lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wide    = {2{store_data[15:0]}};
            end
            MEM_SIZE_WORD: lane_en = 4'b1111;
            default:       lane_en = 4'b0000;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign store_word[8*l+7:8*l] = lane_en[l] ? wide[8*l+7:8*l] : old_word[8*l+7:8*l];
    end

    assign shifted = old_word >> {addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        load_word = old_word;
        case (size)
            MEM_SIZE_BYTE: load_word = zero_ext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            MEM_SIZE_HALF: load_word = zero_ext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default:       load_word = old_word;
        endcase
    end

endmodule

// File: rtl/mips_data_mem_sized.sv
// Clocked MIPS data memory with byte/half/word access, programmable wait
// states and a busy/ready handshake. Misaligned, reserved-size, conflicting
// or out-of-range requests complete immediately with mem_fault=1.
//   clock, reset        : rising-edge clock, async active-high reset
//   mem_address         : byte address
//   write_data          : right-justified store data
//   sig_mem_read/write  : load / store request (hold until mem_ready)
//   mem_size            : 00 byte, 01 half, 10 word, 11 reserved
//   mem_unsigned        : zero-extend byte/half loads
//   read_data           : last load result, held between loads
//   mem_busy            : FSM not idle
//   mem_ready           : one-cycle completion pulse
//   mem_fault           : qualifies mem_ready, 1 = request rejected
module mips_data_mem_sized
    import mips_data_mem_sized_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data,
    input  logic        sig_mem_read,
    input  logic        sig_mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] read_data,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    // Memory contents start at zero; not touched by reset.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
    end

    mem_state_e  state, state_next;
    logic [3:0]  cnt;
    logic [AW+1:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic        fault_q;

    logic        req_fault;
    logic        accept;
    logic        do_access;
    logic [31:0] old_word;
    logic [31:0] store_word;
    logic [31:0] load_word;

    // Fault is judged on the live inputs at acceptance, so only the
    // in-range address bits need capturing.
    assign req_fault = (sig_mem_read & sig_mem_write)
                     | (mem_size == MEM_SIZE_RSVD)
                     | ((mem_size == MEM_SIZE_HALF) & mem_address[0])
                     | ((mem_size == MEM_SIZE_WORD) & (mem_address[1:0] != 2'b00))
                     | (mem_address >= 32'(DEPTH_WORDS * WORD_BYTES));

    assign old_word = mem[addr_q[AW+1:2]];

    mips_mem_lane_align u_align (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .zero_ext   (uns_q),
        .old_word   (old_word),
        .store_data (data_q),
        .store_word (store_word),
        .load_word  (load_word)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            ST_IDLE: if (sig_mem_read | sig_mem_write) begin
                accept     = 1'b1;
                state_next = req_fault ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (cnt == 4'd0) begin
                do_access  = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            data_q    <= 32'h0;
            size_q    <= MEM_SIZE_BYTE;
            uns_q     <= 1'b0;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            read_data <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= mem_address[AW+1:0];
                data_q  <= write_data;
                size_q  <= mem_size;
                uns_q   <= mem_unsigned;
                write_q <= sig_mem_write;
                fault_q <= req_fault;
                cnt     <= 4'(WAIT_STATES);
                if (req_fault) read_data <= 32'h0;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access && !write_q) read_data <= load_word;
        end
    end

    // An async reset pulls state out of WAIT before the commit edge, so an
    // interrupted store never lands.
    always_ff @(posedge clock) begin
        if (do_access && write_q) mem[addr_q[AW+1:2]] <= store_word;
    end

    assign mem_busy  = (state != ST_IDLE);
    assign mem_ready = (state == ST_RESP);
    assign mem_fault = mem_ready & fault_q;

endmodule

// File: tb/tb_mips_data_mem_sized.sv
module tb_mips_data_mem_sized;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // dut: WAIT_STATES=2, dz: WAIT_STATES=0
    logic [31:0] a2 = 0, wd2 = 0, a0 = 0, wd0 = 0;
    logic        rd2 = 0, wr2 = 0, un2 = 0, rd0 = 0, wr0 = 0, un0 = 0;
    logic [1:0]  sz2 = 0, sz0 = 0;
    logic [31:0] q2, q0;
    logic        busy2, rdy2, flt2, busy0, rdy0, flt0;

    mips_data_mem_sized #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clock(clock), .reset(reset), .mem_address(a2), .write_data(wd2),
        .sig_mem_read(rd2), .sig_mem_write(wr2), .mem_size(sz2), .mem_unsigned(un2),
        .read_data(q2), .mem_busy(busy2), .mem_ready(rdy2), .mem_fault(flt2)
    );

    mips_data_mem_sized #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dz (
        .clock(clock), .reset(reset), .mem_address(a0), .write_data(wd0),
        .sig_mem_read(rd0), .sig_mem_write(wr0), .mem_size(sz0), .mem_unsigned(un0),
        .read_data(q0), .mem_busy(busy0), .mem_ready(rdy0), .mem_fault(flt0)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request on the selected DUT (z=1 -> WAIT_STATES=0 instance),
    // hold it until mem_ready, then drop it and look one edge further.
    task automatic txn(input bit z, input logic r, input logic w, input logic [1:0] sz,
                       input logic un, input logic [31:0] a, input logic [31:0] wd,
                       output int edges, output logic [31:0] q, output logic f,
                       output logic busy1, output logic rdy_after);
        logic rdy;
        if (z) begin a0 = a; wd0 = wd; rd0 = r; wr0 = w; sz0 = sz; un0 = un; end
        else   begin a2 = a; wd2 = wd; rd2 = r; wr2 = w; sz2 = sz; un2 = un; end
        edges = 0;
        busy1 = 1'b0;
        rdy   = 1'b0;
        while (!rdy && edges < 40) begin
            @(posedge clock); #1;
            edges++;
            if (edges == 1) busy1 = z ? busy0 : busy2;
            rdy = z ? rdy0 : rdy2;
        end
        if (!rdy) chk("timeout", {31'h0, rdy}, 32'h1);
        q = z ? q0 : q2;
        f = z ? flt0 : flt2;
        if (z) begin rd0 = 0; wr0 = 0; end
        else   begin rd2 = 0; wr2 = 0; end
        @(posedge clock); #1;
        rdy_after = z ? rdy0 : rdy2;
    endtask

    task automatic st(input bit z, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int e; logic [31:0] q; logic f, b, ra;
        txn(z, 1'b1 ^ 1'b1, 1'b1, sz, 1'b0, a, d, e, q, f, b, ra);
        chk("st_flt", {31'h0, f}, 32'h0);
        chk("st_lat", e, z ? 32'd2 : 32'd4);
    endtask

    task automatic ld(input string tag, input bit z, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] exp);
        int e; logic [31:0] q; logic f, b, ra;
        txn(z, 1'b1, 1'b0, sz, un, a, 32'h0, e, q, f, b, ra);
        chk(tag, q, exp);
        chk({tag, "_flt"}, {31'h0, f}, 32'h0);
        chk({tag, "_1pulse"}, {31'h0, ra}, 32'h0);
    endtask

    task automatic flt(input string tag, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        int e; logic [31:0] q; logic f, b, ra;
        txn(1'b0, r, w, sz, 1'b0, a, d, e, q, f, b, ra);
        chk({tag, "_flt"}, {31'h0, f}, 32'h1);
        chk({tag, "_rd"}, q, 32'h0);
        chk({tag, "_lat"}, e, 32'd1);
    endtask

    initial begin
        int e; logic [31:0] q; logic f, b, ra; int pulses;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_rd", q2, 32'h0);
        chk("rst_busy", {31'h0, busy2}, 32'h0);
        chk("rst_rdy", {31'h0, rdy2}, 32'h0);
        chk("rst_flt", {31'h0, flt2}, 32'h0);

        // 1. lw 0 with full handshake checks
        txn(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, e, q, f, b, ra);
        chk("lw0_busy", {31'h0, b}, 32'h1);
        chk("lw0_lat", e, 32'd4);
        chk("lw0_rd", q, 32'h0);
        chk("lw0_flt", {31'h0, f}, 32'h0);
        chk("lw0_1pulse", {31'h0, ra}, 32'h0);

        // 2. word and byte stores
        st(1'b0, 2'b10, 32'd4, 32'd12);
        ld("lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0000000C);
        st(1'b0, 2'b10, 32'd12, 32'd955);
        st(1'b0, 2'b00, 32'd13, 32'h000000AB);
        ld("lw12", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0000ABBB);

        // 3. lane extraction and extension
        st(1'b0, 2'b10, 32'd8, 32'h80FF7F01);
        ld("lb9", 1'b0, 2'b00, 1'b0, 32'd9, 32'h0000007F);
        ld("lb10", 1'b0, 2'b00, 1'b0, 32'd10, 32'hFFFFFFFF);
        ld("lbu11", 1'b0, 2'b00, 1'b1, 32'd11, 32'h00000080);
        ld("lh10", 1'b0, 2'b01, 1'b0, 32'd10, 32'hFFFF80FF);
        ld("lhu8", 1'b0, 2'b01, 1'b1, 32'd8, 32'h00007F01);
        ld("lwu8", 1'b0, 2'b10, 1'b1, 32'd8, 32'h80FF7F01);
        st(1'b0, 2'b01, 32'd14, 32'h0000BEEF);
        ld("lw12h", 1'b0, 2'b10, 1'b0, 32'd12, 32'hBEEFABBB);

        // 4. faults leave memory alone
        flt("lw6", 1'b1, 1'b0, 2'b10, 32'd6, 32'h0);
        flt("sh5", 1'b0, 1'b1, 2'b01, 32'd5, 32'h0000FFFF);
        ld("lw4_after", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0000000C);
        flt("rdwr", 1'b1, 1'b1, 2'b10, 32'd8, 32'h0);
        ld("lw8_after", 1'b0, 2'b10, 1'b0, 32'd8, 32'h80FF7F01);
        flt("lw1024", 1'b1, 1'b0, 2'b10, 32'd1024, 32'h0);
        flt("rsvd", 1'b0, 1'b1, 2'b11, 32'd12, 32'hDEADDEAD);
        ld("lw12_after", 1'b0, 2'b10, 1'b0, 32'd12, 32'hBEEFABBB);
        st(1'b0, 2'b00, 32'd1023, 32'h0000005A);
        ld("lbu1023", 1'b0, 2'b00, 1'b1, 32'd1023, 32'h0000005A);

        // 5. reset during WAIT discards the store
        a2 = 32'd16; wd2 = 32'h55; sz2 = 2'b10; wr2 = 1'b1; rd2 = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        chk("mid_busy", {31'h0, busy2}, 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'h0, busy2}, 32'h0);
        chk("arst_rd", q2, 32'h0);
        chk("arst_rdy", {31'h0, rdy2}, 32'h0);
        wr2 = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        ld("lw16", 1'b0, 2'b10, 1'b0, 32'd16, 32'h0);

        // 6. zero wait states
        st(1'b1, 2'b10, 32'd0, 32'h12345678);
        txn(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, e, q, f, b, ra);
        chk("z_lat", e, 32'd2);
        chk("z_rd", q, 32'h12345678);
        ld("z_lh2", 1'b1, 2'b01, 1'b0, 32'd2, 32'h00001234);
        // held request: accept, RESP, IDLE -> one pulse every 3 edges
        a0 = 32'd0; sz0 = 2'b10; rd0 = 1'b1;
        pulses = 0;
        repeat (9) begin @(posedge clock); #1; if (rdy0) pulses++; end
        rd0 = 1'b0;
        chk("z_b2b", pulses, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
